// File: rtl/aurora_ex_pkg.sv
// Shared encodings for the execute stage: func3/func7 decode constants and the
// iterative multiplier state.
package aurora_ex_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0]  F7_MULDIV  = 7'b0000001;
    localparam int unsigned F7_ALT_BIT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Shift-add multiplier producing the low XLEN bits of a*b after MUL_CYCLES
// iterations; busy covers the detect cycle as well as the iterations.
module ex_mul_iter
    import aurora_ex_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MUL_CYCLES = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(MUL_CYCLES);

    mul_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                        state <= DONE;
                    end
                end
                // The MUL still on the input here must not restart the unit.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = !RST && ((state == IDLE && start) || state == BUSY);
    assign done   = (state == DONE);
    assign result = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, address/link generation, iterative MUL
// and the EX/MEM pipeline register.
module ex_stage
    import aurora_ex_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MUL_CYCLES = 64
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            stall_out,
    input  logic            WRegEn_in,
    input  logic            WMemEn_in,
    input  logic            RMemEn_in,
    input  logic            mem_to_reg_in,
    input  logic            imm_in,
    input  logic            load_in,
    input  logic            store_in,
    input  logic            jal_in,
    input  logic            hz_jalr_in,
    input  logic [XLEN-1:0] R1out_in,
    input  logic [XLEN-1:0] R2out_in,
    input  logic [XLEN-1:0] sign_ext_in,
    input  logic [4:0]      WReg1_in,
    input  logic [2:0]      func3_in,
    input  logic [6:0]      func7_in,
    output logic            WRegEn_out,
    output logic            WMemEn_out,
    output logic            RMemEn_out,
    output logic            mem_to_reg_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [4:0]      WReg1_out,
    output logic [2:0]      func3_out
);

    localparam int unsigned SH_W = $clog2(XLEN);

    logic            mem_op_c;
    logic            jump_c;
    logic            muldiv_c;
    logic            is_mul_c;
    logic            alt_c;
    logic [XLEN-1:0] op_b_c;
    logic [SH_W-1:0] shamt_c;
    logic [XLEN-1:0] alu_c;
    logic [XLEN-1:0] result_c;
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_result;

    assign mem_op_c = load_in || store_in;
    assign jump_c   = jal_in || hz_jalr_in;
    assign muldiv_c = !imm_in && (func7_in == F7_MULDIV);
    assign is_mul_c = muldiv_c && (func3_in == F3_ADD) && !mem_op_c && !jump_c;
    assign alt_c    = func7_in[F7_ALT_BIT];
    assign op_b_c   = imm_in ? sign_ext_in : R2out_in;
    assign shamt_c  = op_b_c[SH_W-1:0];

    ex_mul_iter #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .CLK    (CLK),
        .RST    (RST),
        .start  (is_mul_c),
        .a      (R1out_in),
        .b      (op_b_c),
        .busy   (mul_busy),
        .done   (mul_done),
        .result (mul_result)
    );

    assign stall_out = mul_busy;

    always_comb begin
        alu_c = '0;
        case (func3_in)
            F3_ADD:  alu_c = (!imm_in && alt_c) ? R1out_in - op_b_c : R1out_in + op_b_c;
            F3_SLL:  alu_c = R1out_in << shamt_c;
            F3_SLT:  alu_c = XLEN'($signed(R1out_in) < $signed(op_b_c));
            F3_SLTU: alu_c = XLEN'(R1out_in < op_b_c);
            F3_XOR:  alu_c = R1out_in ^ op_b_c;
            F3_SRL:  alu_c = alt_c ? $unsigned($signed(R1out_in) >>> shamt_c)
                                   : R1out_in >> shamt_c;
            F3_OR:   alu_c = R1out_in | op_b_c;
            F3_AND:  alu_c = R1out_in & op_b_c;
            default: alu_c = '0;
        endcase
        // Unsupported M-extension encodings fall back to ADD.
        if (muldiv_c) begin
            alu_c = R1out_in + op_b_c;
        end
    end

    always_comb begin
        result_c = alu_c;
        if (mul_done) begin
            result_c = mul_result;
        end else if (mem_op_c) begin
            result_c = R1out_in + sign_ext_in;
        end else if (jump_c) begin
            result_c = sign_ext_in;
        end
    end

    // EX/MEM register; a stalled cycle writes a bubble with all enables low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WRegEn_out     <= 1'b0;
            WMemEn_out     <= 1'b0;
            RMemEn_out     <= 1'b0;
            mem_to_reg_out <= 1'b0;
            alu_result_out <= '0;
            store_data_out <= '0;
            WReg1_out      <= '0;
            func3_out      <= '0;
        end else begin
            WRegEn_out     <= WRegEn_in && !stall_out;
            WMemEn_out     <= WMemEn_in && !stall_out;
            RMemEn_out     <= RMemEn_in && !stall_out;
            mem_to_reg_out <= mem_to_reg_in && !stall_out;
            alu_result_out <= result_c;
            store_data_out <= R2out_in;
            WReg1_out      <= WReg1_in;
            func3_out      <= func3_in;
        end
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 64-bit in-order pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its outputs. It computes ALU results, load/store addresses and jump link values, and registers everything into the EX/MEM boundary. A 64-cycle iterative multiplier handles MUL and stalls the front of the pipeline while it runs.

## Interface
- XLEN, default 64: datapath width. Only 64 is supported.
- MUL_CYCLES, default 64: number of shift-add iterations. Must equal XLEN.

Clock, reset and handshake:
- CLK  in  1  clock. Every register updates on the rising edge.
- RST  in  1  reset. Asynchronous and active-high.
- stall_out  out  1  combinational. While high, the hazard unit freezes PC, IF/ID and ID/EX.

Inputs from ID/EX:
- WRegEn_in, WMemEn_in, RMemEn_in, mem_to_reg_in, imm_in, load_in, store_in, jal_in, hz_jalr_in  in  1 each  control bits.
- R1out_in, R2out_in, sign_ext_in  in  64 each  operands.
- WReg1_in  in  5  destination register.
- func3_in  in  3  RISC-V func3.
- func7_in  in  7  RISC-V func7.

Registered outputs to EX/MEM:
- WRegEn_out, WMemEn_out, RMemEn_out, mem_to_reg_out  out  1 each.
- alu_result_out  out  64.
- store_data_out  out  64.
- WReg1_out  out  5.
- func3_out  out  3  load/store width for the memory stage.

## Operation
- Operand A is R1out_in. Operand B is sign_ext_in when imm_in=1, otherwise R2out_in.
- Loads and stores (load_in or store_in): result = R1out_in + sign_ext_in. store_data_out = R2out_in.
- jal_in or hz_jalr_in: result = sign_ext_in. Decode supplies the link value PC+4 on sign_ext_in for jumps.
- ALU ops, selected by func3:
  - 000: ADD, or SUB when imm_in=0 and func7[5]=1.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when func7[5]=1.
  - 110: OR.
  - 111: AND.
- Shift amount is B[5:0]. All arithmetic wraps modulo 2^64.
- MUL is detected when imm_in=0, func7=0000001 and func3=000. The result is the low 64 bits of A*B; signedness is irrelevant for the low half.
- The other func7=0000001 encodings (MULH, DIV, REM and so on) are not supported. They take the ADD path.
- FSM states:
  - IDLE: single-cycle ops pass straight through. A MUL at the input drives stall_out=1 combinationally. The next edge latches A into mcand, B into mplier, clears acc, sets cnt=0, and moves to BUSY.
  - BUSY: stall_out=1. Each edge does: if mplier[0], acc += mcand; then mcand <<= 1; mplier >>= 1; cnt++. The edge with cnt=MUL_CYCLES-1 moves to DONE. There is no early exit.
  - DONE: stall_out=0 and result = acc. The next edge writes the MUL into EX/MEM with its control bits and returns to IDLE. ID/EX advances on the same edge. The MUL still present on the input in DONE does not restart the multiplier.
- During IDLE-detect and BUSY, EX/MEM captures a bubble: WRegEn_out, WMemEn_out and RMemEn_out are 0; the other fields are don't-care.

## Timing
- Non-MUL ops: 1-cycle latency, input to EX/MEM output on the next edge.
- MUL: occupies EX for MUL_CYCLES+2 = 66 cycles (1 detect + 64 BUSY + 1 DONE).
  - stall_out is high for exactly 65 consecutive cycles.
  - The result appears at EX/MEM on the edge that leaves DONE.
  - EX/MEM receives 65 bubbles before the result.
- Back-to-back MULs: the second one is detected in the cycle after DONE, with no extra gap.
- Reset values: every output is 0, stall_out=0, state=IDLE, acc/mcand/mplier/cnt=0.
- RST asserted mid-MUL: the state returns to IDLE immediately (asynchronously) and stall_out drops the same cycle. The partial product is discarded and never written.
- stall_out depends only on state and the current input decode. It has no path from EX/MEM outputs.

## Structure
- Shared package aurora_ex_pkg holds:
  - func3 constants (F3_ADD through F3_AND).
  - F7_MULDIV = 7'b0000001 and the func7[5] alternate-op bit index.
  - The FSM state enum (IDLE, BUSY, DONE).
- Sub-module ex_mul_iter contains the FSM, cnt, acc, mcand and mplier. Its handshake is start/busy/done/result.
- ex_stage contains the combinational ALU, the operand mux and the EX/MEM output register.

## Test plan
- ADD then SUB back to back: R1=5, R2=7 gives 0x000000000000000C, then 0xFFFFFFFFFFFFFFFE. WRegEn_out=1 and stall_out=0 throughout.
- SRA with imm: R1=0x8000000000000000, sign_ext=4, func7[5]=1 gives 0xF800000000000000. SLTU of 1 vs 0xFFFFFFFFFFFFFFFF gives 1.
- Load: R1=0x1000, sign_ext=-8 gives alu_result_out=0xFF8, RMemEn_out=1 and func3_out passed through.
- MUL: 3 × 0xFFFFFFFFFFFFFFFB gives 0xFFFFFFFFFFFFFFF1.
  - stall_out is high for exactly 65 cycles.
  - WRegEn_out=0 for 65 edges, then 1 with the result and WReg1_out.
- Two consecutive MULs (6×7, then 0×X): the results are 42, then 0. The second result arrives exactly 66 cycles after the first.
- RST pulsed at BUSY cycle 30: all outputs are 0 and stall_out=0 within the same cycle. After release, a following ADD completes in 1 cycle with the correct result.
